mem_responder: RTL and testbench

Memory-side responder for the multicycle CPU's data/instruction memory port. It accepts one read or write request at a time from the control path, inserts a configurable number of wait states, and performs the access on an internal single-port RAM. It returns read data with a one-cycle `Ack` pulse. It sits between the datapath memory-address/data muxes and the RAM, and exports `Busy` so the control path can hold its state while an access is outstanding.

---
 rtl/mem_responder.sv | 123 ++++++++++++
 tb/tb_mem_responder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the multicycle CPU memory port.
// Accepts one read or write at a time, waits WAIT_CYC cycles, performs the
// access on an internal single-port RAM, then pulses Ack for one cycle.
//
// Ports:
//   CLK      in   sole clock, rising edge
//   RESET_N  in   asynchronous active-low reset
//   Req      in   request valid (level), sampled only in IDLE
//   We       in   1 = write, 0 = read; captured with Req
//   Addr     in   word address; captured with Req
//   WData    in   write data; captured with Req
//   Ack      out  one-cycle completion pulse (read or write)
//   RData    out  registered read data, held until the next read completes
//   Busy     out  high whenever the FSM is not in IDLE
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for Req; latches We/Addr/WData and loads wait count
// WAIT   | counting down the wait states
// ACCESS | RAM write or RData load happens at the exiting edge
// RESP   | Ack high for this single cycle, Busy still high

module mem_responder #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 10,
  parameter int WAIT_CYC = 1
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              Req,
  input  logic              We,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] WData,
  output logic              Ack,
  output logic [DATA_W-1:0] RData,
  output logic              Busy
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'b0001,
    S_WAIT   = 4'b0010,
    S_ACCESS = 4'b0100,
    S_RESP   = 4'b1000
  } state_t;

  localparam logic [3:0] LP_WAIT = 4'(WAIT_CYC);

  state_t            r_state;
  state_t            w_next;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [3:0]        r_cnt;
  logic              w_accept;

  // Contents are intentionally not reset.
  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  assign w_accept = (r_state == S_IDLE) && Req;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (Req) begin
          w_next = (WAIT_CYC > 0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd1) begin
          w_next = S_ACCESS;
        end
      end
      S_ACCESS: w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_we    <= We;
        r_addr  <= Addr;
        r_wdata <= WData;
        r_cnt   <= LP_WAIT;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if ((r_state == S_ACCESS) && !r_we) begin
        r_rdata <= r_mem[r_addr];
      end
    end
  end

  // Reset forces r_state to IDLE immediately, so a write that has not yet
  // left ACCESS can never reach the RAM.
  always_ff @(posedge CLK) begin
    if ((r_state == S_ACCESS) && r_we) begin
      r_mem[r_addr] <= r_wdata;
    end
  end

  assign Ack   = (r_state == S_RESP);
  assign Busy  = (r_state != S_IDLE);
  assign RData = r_rdata;

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder. Four instances with WAIT_CYC = 3, 1, 0, 2
// share clock and reset; each scenario drives one instance at a time.
// Expected responses go into a queue when a request is issued; a monitor
// pops and compares whenever any instance raises Ack.

module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req   [4];
  logic        we    [4];
  logic [9:0]  addr  [4];
  logic [15:0] wdata [4];
  logic        ack   [4];
  logic [15:0] rdata [4];
  logic        busy  [4];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ack_cnt [4];
  logic [15:0] lastrd [4];

  typedef struct {
    int          inst;
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t q[$];
  exp_t e_got;

  bit [15:0] mdl   [8];
  bit        valid [8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder #(.DATA_W(16), .ADDR_W(10), .WAIT_CYC(3)) u0 (
    .CLK(clk), .RESET_N(rst_n), .Req(req[0]), .We(we[0]), .Addr(addr[0]),
    .WData(wdata[0]), .Ack(ack[0]), .RData(rdata[0]), .Busy(busy[0]));
  mem_responder #(.DATA_W(16), .ADDR_W(10), .WAIT_CYC(1)) u1 (
    .CLK(clk), .RESET_N(rst_n), .Req(req[1]), .We(we[1]), .Addr(addr[1]),
    .WData(wdata[1]), .Ack(ack[1]), .RData(rdata[1]), .Busy(busy[1]));
  mem_responder #(.DATA_W(16), .ADDR_W(10), .WAIT_CYC(0)) u2 (
    .CLK(clk), .RESET_N(rst_n), .Req(req[2]), .We(we[2]), .Addr(addr[2]),
    .WData(wdata[2]), .Ack(ack[2]), .RData(rdata[2]), .Busy(busy[2]));
  mem_responder #(.DATA_W(16), .ADDR_W(10), .WAIT_CYC(2)) u3 (
    .CLK(clk), .RESET_N(rst_n), .Req(req[3]), .We(we[3]), .Addr(addr[3]),
    .WData(wdata[3]), .Ack(ack[3]), .RData(rdata[3]), .Busy(busy[3]));

  function automatic int wcyc(input int i);
    case (i)
      0:       return 3;
      1:       return 1;
      2:       return 0;
      default: return 2;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h (cyc=%0d)", nm, got, want, cyc);
    end
  endtask

  // Writes expect RData to still show the last read result of that instance.
  task automatic push_exp(input int i, input bit w, input logic [15:0] exp_rd, input int n);
    exp_t e;
    if (!w) lastrd[i] = exp_rd;
    e.inst = i;
    e.data = lastrd[i];
    e.due  = n + wcyc(i) + 1;
    q.push_back(e);
  endtask

  // One isolated request: Req high for exactly the acceptance edge, then
  // Busy is checked cycle by cycle until the instance returns to IDLE.
  task automatic issue(input int i, input bit w, input logic [9:0] a,
                       input logic [15:0] d, input logic [15:0] exp_rd,
                       input bit glitch);
    int n;
    @(negedge clk);
    req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d;
    @(posedge clk); #1;
    n = cyc;
    req[i] = 1'b0;
    push_exp(i, w, exp_rd, n);
    if (glitch) begin
      addr[i]  = a + 10'd1;
      we[i]    = ~w;
      wdata[i] = 16'hFFFF;
    end
    for (int k = 0; k < wcyc(i) + 2; k++) begin
      chk("busy_high", {31'd0, busy[i]}, 32'd1);
      @(posedge clk); #1;
    end
    chk("busy_low", {31'd0, busy[i]}, 32'd0);
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ack[i] === 1'b1) begin
        ack_cnt[i]++;
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_ack inst=%0d cyc=%0d", i, cyc);
        end else begin
          e_got = q.pop_front();
          if (e_got.inst != i || e_got.due != cyc || rdata[i] !== e_got.data) begin
            bad++;
            $display("FAIL ack_check got inst=%0d cyc=%0d rdata=%h want inst=%0d cyc=%0d rdata=%h",
                     i, cyc, rdata[i], e_got.inst, e_got.due, e_got.data);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int acks_before;
    logic [9:0]  a;
    logic [15:0] d;
    bit          w;

    for (int i = 0; i < 4; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
      ack_cnt[i] = 0; lastrd[i] = 16'h0000;
    end
    for (int i = 0; i < 8; i++) begin
      mdl[i] = '0; valid[i] = 1'b0;
    end

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("rst_ack",   {31'd0, ack[i]},  32'd0);
      chk("rst_busy",  {31'd0, busy[i]}, 32'd0);
      chk("rst_rdata", {16'd0, rdata[i]}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of a write's WAIT phase (WAIT_CYC=3).
    issue(0, 1'b1, 10'h040, 16'h1111, 16'h0000, 1'b0);
    issue(0, 1'b0, 10'h040, 16'h0000, 16'h1111, 1'b0);
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 10'h040; wdata[0] = 16'h2222;
    @(posedge clk); #1;
    req[0] = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy_before", {31'd0, busy[0]}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_ack",   {31'd0, ack[0]},  32'd0);
    chk("abort_busy",  {31'd0, busy[0]}, 32'd0);
    chk("abort_rdata", {16'd0, rdata[0]}, 32'd0);
    for (int i = 0; i < 4; i++) lastrd[i] = 16'h0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(0, 1'b0, 10'h040, 16'h0000, 16'h1111, 1'b0);

    // Single write then read, WAIT_CYC=1.
    issue(1, 1'b1, 10'h005, 16'hBEEF, 16'h0000, 1'b0);
    issue(1, 1'b0, 10'h005, 16'h0000, 16'hBEEF, 1'b0);

    // Read-after-write hold.
    issue(1, 1'b1, 10'h020, 16'h5555, 16'h0000, 1'b0);
    issue(1, 1'b0, 10'h020, 16'h0000, 16'h5555, 1'b0);
    issue(1, 1'b1, 10'h021, 16'h0001, 16'h0000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rdata_hold", {16'd0, rdata[1]}, 32'h5555);

    // WAIT_CYC=0 with Req held high: W 1234, R, W 4321, R on the top address.
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b1; addr[2] = 10'h3FF; wdata[2] = 16'h1234;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      n = cyc;
      chk("b2b_busy", {31'd0, busy[2]}, 32'd1);
      case (k)
        0: push_exp(2, 1'b1, 16'h0000, n);
        1: push_exp(2, 1'b0, 16'h1234, n);
        2: push_exp(2, 1'b1, 16'h0000, n);
        default: push_exp(2, 1'b0, 16'h4321, n);
      endcase
      we[2]    = (k == 1);
      wdata[2] = 16'h4321;
      if (k == 3) req[2] = 1'b0;
      repeat (3) begin
        @(posedge clk); #1;
      end
    end
    chk("b2b_busy_end", {31'd0, busy[2]}, 32'd0);

    // Input changes while busy are ignored (WAIT_CYC=2).
    issue(3, 1'b1, 10'h010, 16'h00AA, 16'h0000, 1'b0);
    issue(3, 1'b1, 10'h011, 16'h0BBB, 16'h0000, 1'b0);
    issue(3, 1'b0, 10'h010, 16'h0000, 16'h00AA, 1'b1);
    issue(3, 1'b0, 10'h011, 16'h0000, 16'h0BBB, 1'b0);

    // 50 random requests on a small address window, WAIT_CYC=2.
    acks_before = ack_cnt[3];
    for (int k = 0; k < 50; k++) begin
      n = $urandom_range(0, 7);
      a = 10'h100 + 10'(n);
      w = !valid[n] || ($urandom_range(0, 1) == 1);
      d = 16'($urandom);
      if (w) begin
        issue(3, 1'b1, a, d, 16'h0000, 1'b0);
        mdl[n] = d;
        valid[n] = 1'b1;
      end else begin
        issue(3, 1'b0, a, 16'h0000, mdl[n], 1'b0);
      end
    end
    repeat (4) @(negedge clk);
    chk("random_ack_count", 32'(ack_cnt[3] - acks_before), 32'd50);
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
